// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - EX/MEM/WB destination scoreboard driving forwarding, load-use stall and mispredict flush.
// Optional macro HAZARD_PERF_COUNTER_EN adds saturating stallCount/flushCount outputs.
module hazard_controller #(
   parameter int                    REG_ADDR_W       = 5,
   parameter int                    LOAD_USE_PENALTY = 1,
   parameter int                    CNT_W            = 32,
   parameter int                    ALU_OP_W         = 2,
   parameter logic [ALU_OP_W-1:0]   ALU_OP_TYPE_REG  = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  decodeValid,
   input  logic [REG_ADDR_W-1:0] rs1Addr,
   input  logic [REG_ADDR_W-1:0] rs2Addr,
   input  logic [ALU_OP_W-1:0]   aluOp1Type,
   input  logic [ALU_OP_W-1:0]   aluOp2Type,
   input  logic                  isStore,
   input  logic [REG_ADDR_W-1:0] rdAddr,
   input  logic                  rdWrite,
   input  logic                  isLoad,
   input  logic                  brMispredict,
   output logic                  stall,
   output logic                  flush,
   output logic [1:0]            fwdRs1Sel,
   output logic [1:0]            fwdRs2Sel
`ifdef HAZARD_PERF_COUNTER_EN
   ,
   output logic [CNT_W-1:0]      stallCount,
   output logic [CNT_W-1:0]      flushCount
`endif
);

   localparam logic [1:0] PEN_M1 = 2'(LOAD_USE_PENALTY - 1);

   if (LOAD_USE_PENALTY < 1 || LOAD_USE_PENALTY > 3 || CNT_W < 1) begin : g_bad_param
      $error("hazard_controller: LOAD_USE_PENALTY must be 1..3 and CNT_W >= 1");
   end

   logic                  v_ex, v_mem, v_wb, ld_ex;
   logic [REG_ADDR_W-1:0] rd_ex, rd_mem, rd_wb;
   logic [1:0]            cnt, cnt_next;
   logic                  use_rs1, use_rs2, hazard, issue_v;

   assign use_rs1 = decodeValid && (aluOp1Type == ALU_OP_TYPE_REG) && (rs1Addr != '0);
   assign use_rs2 = decodeValid && ((aluOp2Type == ALU_OP_TYPE_REG) || isStore) && (rs2Addr != '0);

   // Youngest producer wins; use_* already excludes x0.
   always_comb begin
      fwdRs1Sel = 2'b00;
      fwdRs2Sel = 2'b00;
      if (use_rs1) begin
         if (v_ex && rd_ex == rs1Addr)        fwdRs1Sel = 2'b01;
         else if (v_mem && rd_mem == rs1Addr) fwdRs1Sel = 2'b10;
         else if (v_wb && rd_wb == rs1Addr)   fwdRs1Sel = 2'b11;
      end
      if (use_rs2) begin
         if (v_ex && rd_ex == rs2Addr)        fwdRs2Sel = 2'b01;
         else if (v_mem && rd_mem == rs2Addr) fwdRs2Sel = 2'b10;
         else if (v_wb && rd_wb == rs2Addr)   fwdRs2Sel = 2'b11;
      end
   end

   assign hazard  = v_ex && ld_ex &&
                    ((use_rs1 && rd_ex == rs1Addr) || (use_rs2 && rd_ex == rs2Addr));
   assign flush   = brMispredict && !rst;
   assign stall   = !rst && !brMispredict && ((cnt != 2'd0) || hazard);
   assign issue_v = decodeValid && rdWrite && (rdAddr != '0) && !stall && !flush;

   always_comb begin
      cnt_next = cnt;
      if (brMispredict)      cnt_next = 2'd0;
      else if (cnt != 2'd0)  cnt_next = cnt - 2'd1;
      else if (hazard)       cnt_next = PEN_M1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_ex   <= 1'b0;
         v_mem  <= 1'b0;
         v_wb   <= 1'b0;
         ld_ex  <= 1'b0;
         rd_ex  <= '0;
         rd_mem <= '0;
         rd_wb  <= '0;
         cnt    <= 2'd0;
      end else begin
         v_wb   <= v_mem;
         rd_wb  <= rd_mem;
         v_mem  <= v_ex;
         rd_mem <= rd_ex;
         v_ex   <= issue_v;
         rd_ex  <= rdAddr;
         ld_ex  <= isLoad && issue_v;
         cnt    <= cnt_next;
      end
   end

`ifdef HAZARD_PERF_COUNTER_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         if (stall && stallCount != '1) stallCount <= stallCount + 1'b1;
         if (flush && flushCount != '1) flushCount <= flushCount + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller at LOAD_USE_PENALTY 1 and 2.
module tb_hazard_controller;
   localparam logic [1:0] REG = 2'd0;
   localparam logic [1:0] IMM = 2'd1;

   logic       clk = 1'b0;
   logic       rst;
   logic       decodeValid, isStore, rdWrite, isLoad, brMispredict;
   logic [4:0] rs1Addr, rs2Addr, rdAddr;
   logic [1:0] aluOp1Type, aluOp2Type;

   logic       stall_a, flush_a, stall_b, flush_b;
   logic [1:0] f1_a, f2_a, f1_b, f2_b;
`ifdef HAZARD_PERF_COUNTER_EN
   logic [31:0] sc_a, fc_a;
   logic [1:0]  sc_b, fc_b;
`endif

   hazard_controller #(.REG_ADDR_W(5), .LOAD_USE_PENALTY(1), .CNT_W(32)) dut_a (
      .clk(clk), .rst(rst), .decodeValid(decodeValid), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
      .aluOp1Type(aluOp1Type), .aluOp2Type(aluOp2Type), .isStore(isStore), .rdAddr(rdAddr),
      .rdWrite(rdWrite), .isLoad(isLoad), .brMispredict(brMispredict),
      .stall(stall_a), .flush(flush_a), .fwdRs1Sel(f1_a), .fwdRs2Sel(f2_a)
`ifdef HAZARD_PERF_COUNTER_EN
      , .stallCount(sc_a), .flushCount(fc_a)
`endif
   );

   hazard_controller #(.REG_ADDR_W(5), .LOAD_USE_PENALTY(2), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .decodeValid(decodeValid), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
      .aluOp1Type(aluOp1Type), .aluOp2Type(aluOp2Type), .isStore(isStore), .rdAddr(rdAddr),
      .rdWrite(rdWrite), .isLoad(isLoad), .brMispredict(brMispredict),
      .stall(stall_b), .flush(flush_b), .fwdRs1Sel(f1_b), .fwdRs2Sel(f2_b)
`ifdef HAZARD_PERF_COUNTER_EN
      , .stallCount(sc_b), .flushCount(fc_b)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sig;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [31:0] observe(int sig);
      case (sig)
         0: return {31'd0, stall_a};
         1: return {31'd0, flush_a};
         2: return {30'd0, f1_a};
         3: return {30'd0, f2_a};
         4: return {31'd0, stall_b};
         5: return {31'd0, flush_b};
         6: return {30'd0, f1_b};
         7: return {30'd0, f2_b};
`ifdef HAZARD_PERF_COUNTER_EN
         8:  return sc_a;
         9:  return fc_a;
         10: return {30'd0, sc_b};
         11: return {30'd0, fc_b};
`endif
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic exp_push(string tag, int sig, logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   // d: 0 = PENALTY 1 instance, 1 = PENALTY 2 instance
   task automatic exp_one(string tag, int d, logic s, logic f, logic [1:0] a, logic [1:0] b);
      exp_push({tag, "_stall"}, d*4 + 0, {31'd0, s});
      exp_push({tag, "_flush"}, d*4 + 1, {31'd0, f});
      exp_push({tag, "_fwd1"},  d*4 + 2, {30'd0, a});
      exp_push({tag, "_fwd2"},  d*4 + 3, {30'd0, b});
   endtask

   task automatic exp_both(string tag, logic s, logic f, logic [1:0] a, logic [1:0] b);
      exp_one({tag, "_p1"}, 0, s, f, a, b);
      exp_one({tag, "_p2"}, 1, s, f, a, b);
   endtask

   task automatic drain();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.sig);
         checks++;
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic drv(bit dv, logic [4:0] r1, logic [1:0] o1, logic [4:0] r2, logic [1:0] o2,
                      bit st, logic [4:0] rd, bit wr, bit ld, bit bm);
      decodeValid  = dv;
      rs1Addr      = r1;
      aluOp1Type   = o1;
      rs2Addr      = r2;
      aluOp2Type   = o2;
      isStore      = st;
      rdAddr       = rd;
      rdWrite      = wr;
      isLoad       = ld;
      brMispredict = bm;
   endtask

   task automatic nop();
      drv(0, 0, IMM, 0, IMM, 0, 0, 0, 0, 0);
   endtask

   task automatic step();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nop();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      // Reset gates flush/stall even with live hazard-looking inputs.
      rst = 1'b1;
      drv(1, 5, REG, 5, REG, 0, 5, 1, 1, 1);
      #2;
      exp_both("reset", 0, 0, 2'd0, 2'd0);
`ifdef HAZARD_PERF_COUNTER_EN
      exp_push("reset_sc_a", 8, 0);
      exp_push("reset_fc_a", 9, 0);
      exp_push("reset_sc_b", 10, 0);
      exp_push("reset_fc_b", 11, 0);
`endif
      step();
      rst = 1'b0;

      // ADD x5 then three readers walk EX -> MEM -> WB -> RF
      drv(1, 0, IMM, 0, IMM, 0, 5, 1, 0, 0);
      exp_both("add_issue", 0, 0, 2'd0, 2'd0);
      step();
      drv(1, 5, REG, 5, REG, 0, 0, 0, 0, 0);
      exp_both("fwd_ex", 0, 0, 2'd1, 2'd1);
      step();
      exp_both("fwd_mem", 0, 0, 2'd2, 2'd2);
      step();
      exp_both("fwd_wb", 0, 0, 2'd3, 2'd3);
      step();
      exp_both("fwd_rf", 0, 0, 2'd0, 2'd0);
      step();

      // LW x7 then SW reading rs2=x7 through the store path
      do_reset();
      drv(1, 0, IMM, 0, IMM, 0, 7, 1, 1, 0);
      exp_both("lw_issue", 0, 0, 2'd0, 2'd0);
      step();
      drv(1, 0, IMM, 7, IMM, 1, 0, 0, 0, 0);
      exp_both("lu_stall", 1, 0, 2'd0, 2'd1);
      step();
      exp_one("lu_p1_done", 0, 0, 0, 2'd0, 2'd2);
      exp_one("lu_p2_hold", 1, 1, 0, 2'd0, 2'd2);
      step();
      exp_one("lu_p1_wb", 0, 0, 0, 2'd0, 2'd3);
      exp_one("lu_p2_done", 1, 0, 0, 2'd0, 2'd3);
      step();

      // x0 destination (even as a load) never forwards nor stalls
      do_reset();
      drv(1, 0, IMM, 0, IMM, 0, 0, 1, 1, 0);
      exp_both("x0_issue", 0, 0, 2'd0, 2'd0);
      step();
      drv(1, 0, REG, 0, REG, 0, 0, 0, 0, 0);
      exp_both("x0_read", 0, 0, 2'd0, 2'd0);
      step();

      // Load-use hazard coinciding with mispredict
      do_reset();
      drv(1, 0, IMM, 0, IMM, 0, 3, 1, 1, 0);
      step();
      drv(1, 3, REG, 0, IMM, 0, 0, 0, 0, 1);
      exp_both("flush_hz", 0, 1, 2'd1, 2'd0);
      step();
      drv(1, 3, REG, 0, IMM, 0, 0, 0, 0, 0);
      exp_both("post_flush", 0, 0, 2'd2, 2'd0);
      step();

      // Asynchronous reset during the cnt=1 stall of the PENALTY 2 instance
      do_reset();
      drv(1, 0, IMM, 0, IMM, 0, 4, 1, 1, 0);
      step();
      drv(1, 4, REG, 0, IMM, 0, 0, 0, 0, 0);
      exp_both("lu2", 1, 0, 2'd1, 2'd0);
      step();
      exp_one("cnt1_stall", 1, 1, 0, 2'd2, 2'd0);
      drain();
      rst = 1'b1;
      #1;
      exp_both("rst_async", 0, 0, 2'd0, 2'd0);
      drain();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drv(1, 4, REG, 4, REG, 0, 0, 0, 0, 0);
      exp_both("post_rst", 0, 0, 2'd0, 2'd0);
      step();

`ifdef HAZARD_PERF_COUNTER_EN
      // Three load-use hazards and two flushes; the 2-bit counters saturate
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drv(1, 0, IMM, 0, IMM, 0, 1, 1, 1, 0);
         step();
         drv(1, 1, REG, 0, IMM, 0, 0, 0, 0, 0);
         step();
         nop();
         step();
         step();
      end
      drv(0, 0, IMM, 0, IMM, 0, 0, 0, 0, 1);
      step();
      step();
      nop();
      exp_push("perf_sc_a", 8, 3);
      exp_push("perf_fc_a", 9, 2);
      exp_push("perf_sc_b_sat", 10, 3);
      exp_push("perf_fc_b", 11, 2);
      step();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
